// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multdiv results wait in a
// one-entry holding buffer. Optional FORCE-cycle counter enabled by `define WBARB_STALL_CNT_EN.
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              pipe_req,
    input  logic [4:0]        pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              md_valid,
    input  logic [4:0]        md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic              pend_valid,
    output logic [4:0]        pend_rd,
    output logic              proto_err
`ifdef WBARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [4:0]        pend_rd_q, pend_rd_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              p, m;

    assign p          = pipe_req && (pipe_rd != 5'd0);
    assign m          = md_valid && (md_rd != 5'd0);
    assign pend_valid = (state_q != IDLE);
    assign pend_rd    = pend_rd_q;
    assign proto_err  = proto_err_q;

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_data_d = pend_data_q;
        wait_cnt_d  = wait_cnt_q;
        proto_err_d = proto_err_q;
        md_ready    = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        pipe_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                md_ready = 1'b1;
                if (p) begin
                    rf_we    = 1'b1;
                    rf_waddr = pipe_rd;
                    rf_wdata = pipe_data;
                    // Same-rd md result is dropped: the younger pipe write supersedes it.
                    if (m && (md_rd != pipe_rd)) begin
                        state_d     = HOLD;
                        pend_rd_d   = md_rd;
                        pend_data_d = md_data;
                        wait_cnt_d  = '0;
                    end
                end else if (m) begin
                    rf_we    = 1'b1;
                    rf_waddr = md_rd;
                    rf_wdata = md_data;
                end
            end
            HOLD: begin
                if (!p) begin
                    rf_we    = 1'b1;
                    rf_waddr = pend_rd_q;
                    rf_wdata = pend_data_q;
                    state_d  = IDLE;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = pipe_rd;
                    rf_wdata = pipe_data;
                    if (pipe_rd == pend_rd_q) begin
                        state_d = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                        if (wait_cnt_d == LIMIT) state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                pipe_stall = 1'b1;
                rf_we      = 1'b1;
                rf_waddr   = pend_rd_q;
                rf_wdata   = pend_data_q;
                state_d    = IDLE;
                if (pipe_req) proto_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A reset cycle never writes, so a held result is discarded rather than landing.
        if (!clr) begin
            rf_we      = 1'b0;
            rf_waddr   = '0;
            rf_wdata   = '0;
            pipe_stall = 1'b0;
            md_ready   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= IDLE;
            pend_rd_q   <= '0;
            pend_data_q <= '0;
            wait_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_data_q <= pend_data_d;
            wait_cnt_q  <= wait_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef WBARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            stall_cnt_q <= '0;
        end else if ((state_q == FORCE) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, reset sequences, and randomized traffic
// against a queue-based reference model of the write-port priority rules.
module tb_wb_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        pipe_req;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        proto_err;
`ifdef WBARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .clr(clr),
        .pipe_req(pipe_req), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
        .md_ready(md_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .pend_valid(pend_valid), .pend_rd(pend_rd),
        .proto_err(proto_err)
`ifdef WBARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic        clr, pr;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st, mr, pv;
        logic [4:0]  prd_held;
        logic        pe;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic pr, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        @(negedge clk);
        clr = c; pipe_req = pr; pipe_rd = prd; pipe_data = pd;
        md_valid = mv; md_rd = mrd; md_data = md;
        #1;
    endtask

    // reference model state: the holding buffer as a queue of at most one entry
    typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
    wr_t held[$];
    int  blocked;
    bit  forcing;
    bit  perr;

    initial begin
        logic        e_we, e_st, e_mr;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        p, m;
        wr_t         w;

        clr = 1'b0; pipe_req = 1'b0; pipe_rd = '0; pipe_data = '0;
        md_valid = 1'b0; md_rd = '0; md_data = '0;

        // reset with all inputs active, then release with idle inputs
        drive(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'h22);
        drive(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'h22);
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("rst_we", rf_we, 0);
        chk("rst_pv", pend_valid, 0);
        chk("rst_pend_rd", pend_rd, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_mdready", md_ready, 1);
        chk("rst_proto", proto_err, 0);

        //          clr pr prd  pdat        mv mrd  mdat        we wa   wd          st mr pv prd  pe
        tv[0]  = '{1, 0, 5'd0, 32'h0,    1, 5'd7, 32'h1234, 1, 5'd7, 32'h1234, 0, 1, 0, 5'd0, 0};
        tv[1]  = '{1, 1, 5'd3, 32'h33,   1, 5'd9, 32'h99,   1, 5'd3, 32'h33,   0, 1, 0, 5'd0, 0};
        tv[2]  = '{1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    1, 5'd9, 32'h99,   0, 0, 1, 5'd9, 0};
        tv[3]  = '{1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 1, 0, 5'd0, 0};
        tv[4]  = '{1, 1, 5'd3, 32'h33,   1, 5'd9, 32'h99,   1, 5'd3, 32'h33,   0, 1, 0, 5'd0, 0};
        tv[5]  = '{1, 1, 5'd9, 32'hAAAA, 0, 5'd0, 32'h0,    1, 5'd9, 32'hAAAA, 0, 0, 1, 5'd9, 0};
        tv[6]  = '{1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 1, 0, 5'd0, 0};
        tv[7]  = '{1, 1, 5'd1, 32'h11,   1, 5'd9, 32'h99,   1, 5'd1, 32'h11,   0, 1, 0, 5'd0, 0};
        tv[8]  = '{1, 1, 5'd1, 32'h11,   0, 5'd0, 32'h0,    1, 5'd1, 32'h11,   0, 0, 1, 5'd9, 0};
        tv[9]  = '{1, 1, 5'd2, 32'h22,   0, 5'd0, 32'h0,    1, 5'd2, 32'h22,   0, 0, 1, 5'd9, 0};
        tv[10] = '{1, 1, 5'd3, 32'h33,   0, 5'd0, 32'h0,    1, 5'd3, 32'h33,   0, 0, 1, 5'd9, 0};
        tv[11] = '{1, 1, 5'd4, 32'h44,   0, 5'd0, 32'h0,    1, 5'd4, 32'h44,   0, 0, 1, 5'd9, 0};
        tv[12] = '{1, 1, 5'd5, 32'h55,   0, 5'd0, 32'h0,    1, 5'd9, 32'h99,   1, 0, 1, 5'd9, 0};
        tv[13] = '{1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 1, 0, 5'd0, 1};
        tv[14] = '{1, 0, 5'd0, 32'h0,    1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0,    0, 1, 0, 5'd0, 1};
        tv[15] = '{1, 1, 5'd0, 32'h77,   1, 5'd5, 32'h5,    1, 5'd5, 32'h5,    0, 1, 0, 5'd0, 1};
        tv[16] = '{1, 1, 5'd2, 32'h22,   1, 5'd6, 32'h66,   1, 5'd2, 32'h22,   0, 1, 0, 5'd0, 1};

        for (int i = 0; i < 17; i++) begin
            drive(tv[i].clr, tv[i].pr, tv[i].prd, tv[i].pdat, tv[i].mv, tv[i].mrd, tv[i].mdat);
            chk($sformatf("v%0d_we", i), rf_we, tv[i].we);
            chk($sformatf("v%0d_waddr", i), rf_waddr, tv[i].wa);
            chk($sformatf("v%0d_wdata", i), rf_wdata, tv[i].wd);
            chk($sformatf("v%0d_stall", i), pipe_stall, tv[i].st);
            chk($sformatf("v%0d_mdready", i), md_ready, tv[i].mr);
            chk($sformatf("v%0d_pv", i), pend_valid, tv[i].pv);
            if (tv[i].pv) chk($sformatf("v%0d_pend_rd", i), pend_rd, tv[i].prd_held);
            chk($sformatf("v%0d_proto", i), proto_err, tv[i].pe);
`ifdef WBARB_STALL_CNT_EN
            if (i == 13) chk("stall_cnt", stall_cnt, 1);
`endif
        end

        // reset while r6 is held: no write in the reset cycle, buffer gone afterwards
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("rstH_we", rf_we, 0);
        chk("rstH_pv_before", pend_valid, 1);
        chk("rstH_pend_rd_before", pend_rd, 6);
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("rstH_we_after", rf_we, 0);
        chk("rstH_pv_after", pend_valid, 0);
        chk("rstH_pend_rd_after", pend_rd, 0);
        chk("rstH_proto_after", proto_err, 0);
        chk("rstH_mdready_after", md_ready, 1);

        // randomized traffic against the reference model
        held.delete(); blocked = 0; forcing = 0; perr = 0;
        for (int n = 0; n < 3000; n++) begin
            logic c, pr, mv;
            logic [4:0] prd, mrd;
            c   = (n == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            pr  = forcing ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 60);
            prd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            mv  = ($urandom_range(0, 1) == 1);
            mrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            drive(c, pr, prd, $urandom, mv, mrd, $urandom);

            p = pr && (prd != 0);
            m = mv && (mrd != 0);
            e_we = 0; e_wa = 0; e_wd = 0; e_st = 0; e_mr = 0;
            if (!c) begin
                e_mr = 1;
            end else if (forcing) begin
                e_st = 1; e_we = 1; e_wa = held[0].rd; e_wd = held[0].data;
            end else if (held.size() != 0) begin
                e_we = 1;
                if (p) begin e_wa = prd; e_wd = pipe_data; end
                else   begin e_wa = held[0].rd; e_wd = held[0].data; end
            end else begin
                e_mr = 1;
                if (p)      begin e_we = 1; e_wa = prd; e_wd = pipe_data; end
                else if (m) begin e_we = 1; e_wa = mrd; e_wd = md_data; end
            end

            chk("rnd_we", rf_we, e_we);
            chk("rnd_waddr", rf_waddr, e_wa);
            chk("rnd_wdata", rf_wdata, e_wd);
            chk("rnd_stall", pipe_stall, e_st);
            chk("rnd_mdready", md_ready, e_mr);
            chk("rnd_pv", pend_valid, held.size() != 0);
            if (held.size() != 0) chk("rnd_pend_rd", pend_rd, held[0].rd);
            chk("rnd_proto", proto_err, perr);

            if (!c) begin
                held.delete(); blocked = 0; forcing = 0; perr = 0;
            end else if (forcing) begin
                if (pr) perr = 1;
                held.delete(); forcing = 0;
            end else if (held.size() != 0) begin
                if (!p || prd == held[0].rd) begin
                    held.delete();
                end else begin
                    blocked++;
                    if (blocked == LIMIT) forcing = 1;
                end
            end else if (p && m && prd != mrd) begin
                w.rd = mrd; w.data = md_data;
                held.push_back(w);
                blocked = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline writeback stage (MW) and the multi-cycle multdiv unit.
- The pipeline always has priority. A multdiv result that cannot write immediately is held in a one-entry holding buffer (5-bit destination plus 32-bit data).
- A starvation timer forces a one-cycle pipeline stall so the held result drains.
- Also resolves write-after-write ordering on the same destination register, and suppresses writes to r0.

Parameters:
- DATA_W, 32, width of the write data.
- STARVE_LIMIT, 4, consecutive blocked cycles allowed in HOLD before FORCE; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-low.
- pipe_req  in  1  MW stage has a register write this cycle.
- pipe_rd  in  5  MW destination register.
- pipe_data  in  DATA_W  MW write data.
- md_valid  in  1  multdiv result available.
- md_rd  in  5  multdiv destination register.
- md_data  in  DATA_W  multdiv result.
- md_ready  out  1  arbiter accepts the multdiv result this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- pipe_stall  out  1  freeze the pipeline and bubble MW this cycle.
- pend_valid  out  1  holding buffer occupied; used by hazard/bypass logic.
- pend_rd  out  5  destination held in the buffer.
- proto_err  out  1  sticky: pipe_req was seen while pipe_stall was high.

Behaviour:
- Reset: clr==0 at a rising clk edge sets state=IDLE, pend_valid=0, pend_rd=0, pending data=0, wait_cnt=0, proto_err=0.
- Reset outputs: rf_we=0, pipe_stall=0, md_ready=1 (valid once inputs are idle).
- Reset mid-HOLD or mid-FORCE discards the held result with no write.
- All rf_* outputs, md_ready and pipe_stall are combinational from state and inputs; the write lands at the next edge (0-cycle arbitration latency).
- Effective requests ignore r0: p = pipe_req && pipe_rd!=0; m = md_valid && md_rd!=0.
- State machine: IDLE, HOLD, FORCE.
- IDLE: md_ready=1.
  - p only: write pipe.
  - m only: write md directly; stay in IDLE.
  - p and m with pipe_rd==md_rd: write pipe; md result is consumed and dropped (the younger pipe write wins).
  - p and m with different rd: write pipe; capture md into the buffer; go to HOLD with wait_cnt=0.
  - md_valid with md_rd==0: accepted and dropped.
- HOLD: md_ready=0; pend_valid=1.
  - No p: write pending; go to IDLE.
  - p with pipe_rd==pend_rd: write pipe; squash pending; go to IDLE.
  - p with other rd: write pipe; wait_cnt+1. When wait_cnt+1==STARVE_LIMIT, go to FORCE.
- FORCE: pipe_stall=1; md_ready=0; write pending; go to IDLE next cycle.
  - pipe_req must be 0. If it is 1, the pending write still wins, the pipe write is not performed, and proto_err sets and holds until reset.
- Maximum latency from md acceptance to write: STARVE_LIMIT+1 cycles.
- wait_cnt is 4 bits and never wraps (bounded by STARVE_LIMIT).
- rf_waddr/rf_wdata are 0 whenever rf_we=0.

Optional Feature:
- Macro WBARB_STALL_CNT_EN.
- When defined: adds output port stall_cnt [15:0]. It increments on each cycle in FORCE, saturates at 16'hFFFF, and is cleared by clr.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold clr=0 for 2 cycles with all inputs active -> rf_we=0, pend_valid=0, pipe_stall=0, md_ready=1, proto_err=0 after release.
- md alone: md_valid=1, md_rd=5'd7, md_data=32'h1234 in IDLE -> same cycle rf_we=1, rf_waddr=7, rf_wdata=32'h1234, md_ready=1; state stays IDLE.
- Conflict then drain: pipe rd=3, md rd=9 in the same cycle -> pipe writes r3; next cycle pend_valid=1, pend_rd=9, md_ready=0. Pipe idle -> r9 written and state returns to IDLE.
- WAW squash: with r9 held, pipe_req with pipe_rd=9, data=32'hAAAA -> r9=32'hAAAA; pend_valid=0 next cycle; the held value is never written.
- Starvation: hold r9, then pipe writes r1..r4 on 4 consecutive cycles (STARVE_LIMIT=4) -> pipe_stall=1 in cycle 5 with r9 written; pipe_req=1 during that cycle -> proto_err=1 and stays set. With WBARB_STALL_CNT_EN, stall_cnt=1.
- r0 filter and reset mid-HOLD: md_rd=0 -> md_ready=1, rf_we=0. Separately, clr=0 during HOLD -> pending is lost and no write occurs.
